pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Multi-cycle fetch/execute sequencer for the 9-bit-instruction CPU.
- Owns the PC and the instruction register, and feeds the IR to the control decoder.
- Consumes the decoder's Branch/Halt/MemtoReg/MemWrite outputs and the ALU branch-condition flag.
- Gates datapath commits, runs the top-level req/done handshake, and holds a small branch-target table that is configurable while idle.

Parameters:
PC_W, 10, PC / instruction-memory address width
MCODE_W, 9, instruction width
LUT_IDX_W, 2, branch-target table index width (depth 2**LUT_IDX_W)
START_PC, 0, PC loaded on start
MAX_CYCLES, 0, watchdog limit in counted cycles; 0 disables

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req  in  1  start request from testbench/top level
imem_addr  out  PC_W  instruction-memory address (equals pc)
imem_data  in  MCODE_W  combinational instruction-ROM read data
ir  out  MCODE_W  registered instruction, drives decoder instr
ctl_branch  in  1  decoder Branch
ctl_halt  in  1  decoder Halt
ctl_memtoreg  in  1  decoder MemtoReg (load)
ctl_memwrite  in  1  decoder MemWrite (store)
alu_taken  in  1  branch condition from ALU (1 = take)
mem_req  out  1  load/store address phase
commit  out  1  one-cycle enable for register-file / data-memory write
busy  out  1  high in FETCH, EXEC, MEM
done  out  1  program finished
overrun  out  1  fell through the last PC address
timeout  out  1  watchdog expired
cycle_cnt  out  16  counted cycles of the current run, saturating
cfg_we  in  1  branch-table write strobe
cfg_idx  in  LUT_IDX_W  branch-table entry
cfg_data  in  PC_W  branch target value

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, pc=START_PC, ir=0, cycle_cnt=0.
  - done, overrun, timeout, busy, commit, mem_req all 0.
  - Branch table cleared to 0.
- States: IDLE, FETCH, EXEC, MEM, DONE.
- IDLE:
  - cfg_we=1 writes table[cfg_idx]=cfg_data at the clock edge.
  - req=1 at an edge: pc<=START_PC, cycle_cnt<=0, overrun/timeout<=0, go to FETCH.
  - If req and cfg_we are both high, the write takes effect and the start proceeds.
- FETCH: ir<=imem_data at imem_addr=pc; go to EXEC.
- EXEC (decoder inputs valid, derived from ir):
  - ctl_halt=1: go to DONE, no commit, pc unchanged.
  - ctl_memtoreg or ctl_memwrite: mem_req=1 this cycle; go to MEM.
  - Otherwise: commit=1, update pc, go to FETCH.
  - Branch is suppressed (commit still 1, no RegWrite effect required).
- MEM: commit=1, update pc, go to FETCH.
- PC update:
  - If ctl_branch and alu_taken: pc<=table[ir[3+LUT_IDX_W-1:3]]. ir[4:3] is free because bne forces rd_addrB=0.
  - Else pc<=pc+1. These values are sampled in EXEC; the MEM path uses values registered at EXEC.
- Overrun: a non-branching, non-halt instruction at pc=2**PC_W-1 sets overrun=1 and goes to DONE instead of wrapping. The commit for that instruction still occurs.
- Latency: 2 cycles per ALU/branch instruction, 3 per load/store; halt costs 2 cycles (FETCH, EXEC).
- cycle_cnt: increments on every FETCH/EXEC/MEM cycle and saturates at 16'hFFFF.
- Watchdog: if MAX_CYCLES≠0 and cycle_cnt reaches MAX_CYCLES, set timeout=1 and go to DONE at the next edge. This overrides every other transition and suppresses commit in that cycle.
- DONE:
  - done=1, busy=0; pc, cycle_cnt and flags hold.
  - req=0 returns to IDLE and drops done; flags hold until the next start.
- Ignored inputs:
  - req toggling while busy has no effect.
  - cfg_we outside IDLE is ignored.
- Outputs: commit and mem_req are combinational from state; done and busy are registered/decoded from state without glitches.
- Reset asserted mid-run aborts immediately to the reset values; no partial commit follows.

Decomposition:
- Package cpu_seq_pkg:
  - seq_state_t enum (IDLE, FETCH, EXEC, MEM, DONE).
  - CNT_W=16 and the default START_PC.
- Sub-module branch_lut: 2**LUT_IDX_W x PC_W register file with one write port (clocked, async reset to 0) and one combinational read port.

Test Plan:
- Program {0: add, 1: halt}, req=1 → done rises after 4 counted cycles; cycle_cnt=4, commit pulsed once, pc=1, overrun=0.
- Program {0: load, 1: store, 2: halt} → mem_req high in cycles 2 and 5; commit in MEM cycles only; cycle_cnt=8.
- Sequence: cfg_idx=1, cfg_data=10'd7 in IDLE; program {0: bne with ir[4:3]=1 and alu_taken=1, 7: halt} → pc goes 0→7, done, cycle_cnt=4. Repeat with alu_taken=0 → pc goes to 1.
- Sequence: MAX_CYCLES=6, program = branch-to-self loop → timeout=1 and done=1 with cycle_cnt=6; no commit in the final cycle. Drop req → IDLE, done=0.
- Sequence: PC_W=3, START_PC=7, ROM[7]=add → commit once, overrun=1, done=1, pc stays 7.
- Sequence: reset_n pulsed low during MEM → all outputs at reset values asynchronously. Sequence: cfg_we during busy → table unchanged when read after the run.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the fetch/execute sequencer of the 9-bit CPU.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        MEM,
        DONE
    } seq_state_t;

    localparam int CNT_W        = 16;
    localparam int DEF_START_PC = 0;

    // Cycle counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/branch_lut.sv
// Small branch-target register file: one clocked write port, one combinational read port.
module branch_lut #(
    parameter int IDX_W  = 2,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**IDX_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2**IDX_W; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns PC and IR, gates commits and runs the req/done handshake.
module pc_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int PC_W       = 10,
    parameter int MCODE_W    = 9,
    parameter int LUT_IDX_W  = 2,
    parameter int START_PC   = DEF_START_PC,
    parameter int MAX_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req,
    output logic [PC_W-1:0]      imem_addr,
    input  logic [MCODE_W-1:0]   imem_data,
    output logic [MCODE_W-1:0]   ir,
    input  logic                 ctl_branch,
    input  logic                 ctl_halt,
    input  logic                 ctl_memtoreg,
    input  logic                 ctl_memwrite,
    input  logic                 alu_taken,
    output logic                 mem_req,
    output logic                 commit,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic                 timeout,
    output logic [CNT_W-1:0]     cycle_cnt,
    input  logic                 cfg_we,
    input  logic [LUT_IDX_W-1:0] cfg_idx,
    input  logic [PC_W-1:0]      cfg_data
);

    seq_state_t         state, state_nx;
    logic [PC_W-1:0]    pc, mem_pc_q, lut_rdata, exec_target;
    logic [MCODE_W-1:0] ir_q;
    logic [CNT_W-1:0]   cnt, cnt_inc;
    logic               mem_ovr_q, overrun_q, timeout_q, busy_q, done_q;
    logic               in_run, wd_fire, is_mem, take_br, exec_ovr;

    // The table index rides in ir[4:3], which the branch encoding leaves free.
    branch_lut #(
        .IDX_W  (LUT_IDX_W),
        .DATA_W (PC_W)
    ) u_lut (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (cfg_we && (state == IDLE)),
        .widx    (cfg_idx),
        .wdata   (cfg_data),
        .ridx    (ir_q[3 +: LUT_IDX_W]),
        .rdata   (lut_rdata)
    );

    assign in_run      = (state == FETCH) || (state == EXEC) || (state == MEM);
    assign cnt_inc     = sat_inc(cnt);
    assign wd_fire     = (MAX_CYCLES != 0) && in_run && (cnt_inc == CNT_W'(MAX_CYCLES));
    assign is_mem      = ctl_memtoreg || ctl_memwrite;
    assign take_br     = ctl_branch && alu_taken;
    assign exec_target = take_br ? lut_rdata : pc + 1'b1;
    assign exec_ovr    = !take_br && (pc == {PC_W{1'b1}});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            busy_q <= (state_nx == FETCH) || (state_nx == EXEC) || (state_nx == MEM);
            done_q <= (state_nx == DONE);
        end
    end

    // The watchdog overrides every other transition.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (req) state_nx = FETCH;
            FETCH: state_nx = EXEC;
            EXEC: begin
                if (ctl_halt)      state_nx = DONE;
                else if (is_mem)   state_nx = MEM;
                else if (exec_ovr) state_nx = DONE;
                else               state_nx = FETCH;
            end
            MEM:   state_nx = mem_ovr_q ? DONE : FETCH;
            DONE:  if (!req) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (wd_fire) state_nx = DONE;
    end

    always_comb begin
        commit  = 1'b0;
        mem_req = 1'b0;
        if (!wd_fire) begin
            if (state == EXEC && !ctl_halt) begin
                commit  = !is_mem;
                mem_req = is_mem;
            end else if (state == MEM) begin
                commit  = 1'b1;
            end
        end
    end

    // Loads/stores capture their PC outcome in EXEC and apply it in MEM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= PC_W'(START_PC);
            ir_q      <= '0;
            cnt       <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            mem_pc_q  <= '0;
            mem_ovr_q <= 1'b0;
        end else begin
            if (in_run)  cnt       <= cnt_inc;
            if (wd_fire) timeout_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (req) begin
                        pc        <= PC_W'(START_PC);
                        cnt       <= '0;
                        overrun_q <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                FETCH: ir_q <= imem_data;
                EXEC: begin
                    if (!wd_fire && !ctl_halt) begin
                        if (is_mem) begin
                            mem_pc_q  <= exec_target;
                            mem_ovr_q <= exec_ovr;
                        end else if (exec_ovr) begin
                            overrun_q <= 1'b1;
                        end else begin
                            pc <= exec_target;
                        end
                    end
                end
                MEM: begin
                    if (!wd_fire) begin
                        if (mem_ovr_q) overrun_q <= 1'b1;
                        else           pc        <= mem_pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = pc;
    assign ir        = ir_q;
    assign cycle_cnt = cnt;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default build, a watchdog build and a tiny-PC overrun build.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       cfg_we = 1'b0;
    logic [1:0] cfg_idx = '0;
    logic [9:0] cfg_data = '0;

    localparam logic [8:0] ADD   = 9'b000_000_000;
    localparam logic [8:0] LOAD  = 9'b001_000_000;
    localparam logic [8:0] STORE = 9'b010_000_000;
    localparam logic [8:0] HALT  = 9'b111_000_000;

    function automatic logic [8:0] bne(input logic [1:0] idx);
        return {3'd3, 1'b0, idx, 3'b000};
    endfunction

    // Instance a: defaults
    logic req_a = 1'b0, alu_taken_a = 1'b0;
    logic [9:0] imem_addr_a;
    logic [8:0] imem_data_a, ir_a;
    logic ctl_branch_a, ctl_halt_a, ctl_memtoreg_a, ctl_memwrite_a;
    logic mem_req_a, commit_a, busy_a, done_a, overrun_a, timeout_a;
    logic [15:0] cycle_cnt_a;
    logic [8:0] rom_a [1024];

    // Instance b: watchdog at 6 cycles
    logic req_b = 1'b0, alu_taken_b = 1'b0;
    logic [9:0] imem_addr_b;
    logic [8:0] imem_data_b, ir_b;
    logic ctl_branch_b, ctl_halt_b, ctl_memtoreg_b, ctl_memwrite_b;
    logic mem_req_b, commit_b, busy_b, done_b, overrun_b, timeout_b;
    logic [15:0] cycle_cnt_b;
    logic [8:0] rom_b [1024];

    // Instance c: 3-bit PC starting at the last address
    logic req_c = 1'b0, alu_taken_c = 1'b0;
    logic [2:0] imem_addr_c;
    logic [8:0] imem_data_c, ir_c;
    logic ctl_branch_c, ctl_halt_c, ctl_memtoreg_c, ctl_memwrite_c;
    logic mem_req_c, commit_c, busy_c, done_c, overrun_c, timeout_c;
    logic [15:0] cycle_cnt_c;
    logic [8:0] rom_c [8];

    assign imem_data_a    = rom_a[imem_addr_a];
    assign ctl_branch_a   = (ir_a[8:6] == 3'd3);
    assign ctl_halt_a     = (ir_a[8:6] == 3'd7);
    assign ctl_memtoreg_a = (ir_a[8:6] == 3'd1);
    assign ctl_memwrite_a = (ir_a[8:6] == 3'd2);

    assign imem_data_b    = rom_b[imem_addr_b];
    assign ctl_branch_b   = (ir_b[8:6] == 3'd3);
    assign ctl_halt_b     = (ir_b[8:6] == 3'd7);
    assign ctl_memtoreg_b = (ir_b[8:6] == 3'd1);
    assign ctl_memwrite_b = (ir_b[8:6] == 3'd2);

    assign imem_data_c    = rom_c[imem_addr_c];
    assign ctl_branch_c   = (ir_c[8:6] == 3'd3);
    assign ctl_halt_c     = (ir_c[8:6] == 3'd7);
    assign ctl_memtoreg_c = (ir_c[8:6] == 3'd1);
    assign ctl_memwrite_c = (ir_c[8:6] == 3'd2);

    pc_sequencer u_dut_a (
        .clk(clk), .reset_n(reset_n), .req(req_a),
        .imem_addr(imem_addr_a), .imem_data(imem_data_a), .ir(ir_a),
        .ctl_branch(ctl_branch_a), .ctl_halt(ctl_halt_a),
        .ctl_memtoreg(ctl_memtoreg_a), .ctl_memwrite(ctl_memwrite_a),
        .alu_taken(alu_taken_a), .mem_req(mem_req_a), .commit(commit_a),
        .busy(busy_a), .done(done_a), .overrun(overrun_a), .timeout(timeout_a),
        .cycle_cnt(cycle_cnt_a), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data)
    );

    pc_sequencer #(.MAX_CYCLES(6)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .req(req_b),
        .imem_addr(imem_addr_b), .imem_data(imem_data_b), .ir(ir_b),
        .ctl_branch(ctl_branch_b), .ctl_halt(ctl_halt_b),
        .ctl_memtoreg(ctl_memtoreg_b), .ctl_memwrite(ctl_memwrite_b),
        .alu_taken(alu_taken_b), .mem_req(mem_req_b), .commit(commit_b),
        .busy(busy_b), .done(done_b), .overrun(overrun_b), .timeout(timeout_b),
        .cycle_cnt(cycle_cnt_b), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data)
    );

    pc_sequencer #(.PC_W(3), .START_PC(7)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .req(req_c),
        .imem_addr(imem_addr_c), .imem_data(imem_data_c), .ir(ir_c),
        .ctl_branch(ctl_branch_c), .ctl_halt(ctl_halt_c),
        .ctl_memtoreg(ctl_memtoreg_c), .ctl_memwrite(ctl_memwrite_c),
        .alu_taken(alu_taken_c), .mem_req(mem_req_c), .commit(commit_c),
        .busy(busy_c), .done(done_c), .overrun(overrun_c), .timeout(timeout_c),
        .cycle_cnt(cycle_cnt_c), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data[2:0])
    );

    int total = 0;
    int bad = 0;

    // Bit k of a mask is set when the strobe was high in counted cycle k of the run.
    logic [31:0] cmask_a, mmask_a, cmask_b, mmask_b, cmask_c, mmask_c;

    always @(negedge clk) begin
        if (busy_a && cycle_cnt_a < 16'd31) begin
            if (commit_a)  cmask_a[cycle_cnt_a + 16'd1] = 1'b1;
            if (mem_req_a) mmask_a[cycle_cnt_a + 16'd1] = 1'b1;
        end
        if (busy_b && cycle_cnt_b < 16'd31) begin
            if (commit_b)  cmask_b[cycle_cnt_b + 16'd1] = 1'b1;
            if (mem_req_b) mmask_b[cycle_cnt_b + 16'd1] = 1'b1;
        end
        if (busy_c && cycle_cnt_c < 16'd31) begin
            if (commit_c)  cmask_c[cycle_cnt_c + 16'd1] = 1'b1;
            if (mem_req_c) mmask_c[cycle_cnt_c + 16'd1] = 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic done_of(input int w);
        case (w)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    task automatic setReq(input int w, input logic v);
        case (w)
            0:       req_a = v;
            1:       req_b = v;
            default: req_c = v;
        endcase
    endtask

    // cfg_mode: 0 none, 1 table write on the same edge as the start, 2 table writes while busy (plus a req glitch).
    task automatic applyStimulus(input int w, input string tag, input int cfg_mode);
        @(negedge clk);
        cmask_a = '0; mmask_a = '0; cmask_b = '0; mmask_b = '0; cmask_c = '0; mmask_c = '0;
        setReq(w, 1'b1);
        if (cfg_mode == 1) cfg_we = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cfg_mode == 1) cfg_we = 1'b0;
            if (cfg_mode == 2) begin
                cfg_we = 1'b1;
                if (i == 1) setReq(w, 1'b0);
                if (i == 2) setReq(w, 1'b1);
            end
            if (done_of(w)) break;
        end
        cfg_we = 1'b0;
        checkOutput({tag, "_done"}, 32'(done_of(w)), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy_of(w)), 32'd0);
    endtask

    task automatic endRun(input int w, input string tag);
        @(negedge clk);
        setReq(w, 1'b0);
        @(negedge clk);
        checkOutput({tag, "_done_drop"}, 32'(done_of(w)), 32'd0);
        checkOutput({tag, "_idle_busy"}, 32'(busy_of(w)), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            rom_a[i] = HALT;
            rom_b[i] = HALT;
        end
        for (int i = 0; i < 8; i++) rom_c[i] = HALT;
        cmask_a = '0; mmask_a = '0; cmask_b = '0; mmask_b = '0; cmask_c = '0; mmask_c = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_pc",      32'(imem_addr_a), 32'd0);
        checkOutput("rst_ir",      32'(ir_a),        32'd0);
        checkOutput("rst_cnt",     32'(cycle_cnt_a), 32'd0);
        checkOutput("rst_busy",    32'(busy_a),      32'd0);
        checkOutput("rst_done",    32'(done_a),      32'd0);
        checkOutput("rst_commit",  32'(commit_a),    32'd0);
        checkOutput("rst_memreq",  32'(mem_req_a),   32'd0);
        checkOutput("rst_flags",   32'({overrun_a, timeout_a}), 32'd0);
        checkOutput("rst_pc_c",    32'(imem_addr_c), 32'd7);
        reset_n = 1'b1;

        rom_a[0] = ADD; rom_a[1] = HALT;
        applyStimulus(0, "addhalt", 0);
        checkOutput("addhalt_cnt",     32'(cycle_cnt_a), 32'd4);
        checkOutput("addhalt_commits", cmask_a,          32'h4);
        checkOutput("addhalt_pc",      32'(imem_addr_a), 32'd1);
        checkOutput("addhalt_overrun", 32'(overrun_a),   32'd0);
        checkOutput("addhalt_ir",      32'(ir_a),        32'(HALT));
        endRun(0, "addhalt");

        rom_a[0] = LOAD; rom_a[1] = STORE; rom_a[2] = HALT;
        applyStimulus(0, "ldst", 0);
        checkOutput("ldst_cnt",     32'(cycle_cnt_a), 32'd8);
        checkOutput("ldst_memreq",  mmask_a,          32'h24);
        checkOutput("ldst_commits", cmask_a,          32'h48);
        checkOutput("ldst_pc",      32'(imem_addr_a), 32'd2);
        endRun(0, "ldst");

        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_data = 10'd7;
        @(negedge clk);
        cfg_we = 1'b0;
        rom_a[0] = bne(2'd1); rom_a[1] = HALT; rom_a[7] = HALT;
        alu_taken_a = 1'b1;
        applyStimulus(0, "bne_taken", 0);
        checkOutput("bne_taken_pc",      32'(imem_addr_a), 32'd7);
        checkOutput("bne_taken_cnt",     32'(cycle_cnt_a), 32'd4);
        checkOutput("bne_taken_commits", cmask_a,          32'h4);
        endRun(0, "bne_taken");
        alu_taken_a = 1'b0;
        applyStimulus(0, "bne_not", 0);
        checkOutput("bne_not_pc",  32'(imem_addr_a), 32'd1);
        checkOutput("bne_not_cnt", 32'(cycle_cnt_a), 32'd4);
        endRun(0, "bne_not");

        cfg_idx = 2'd2; cfg_data = 10'd5;
        rom_a[0] = bne(2'd2); rom_a[5] = HALT;
        alu_taken_a = 1'b1;
        applyStimulus(0, "cfg_start", 1);
        checkOutput("cfg_start_pc", 32'(imem_addr_a), 32'd5);
        endRun(0, "cfg_start");

        cfg_idx = 2'd2; cfg_data = 10'd9;
        rom_a[0] = ADD; rom_a[1] = HALT;
        applyStimulus(0, "cfg_busy", 2);
        checkOutput("cfg_busy_pc",  32'(imem_addr_a), 32'd1);
        checkOutput("cfg_busy_cnt", 32'(cycle_cnt_a), 32'd4);
        endRun(0, "cfg_busy");
        rom_a[0] = bne(2'd2); rom_a[9] = HALT;
        applyStimulus(0, "tbl_kept", 0);
        checkOutput("tbl_kept_pc", 32'(imem_addr_a), 32'd5);
        endRun(0, "tbl_kept");

        rom_b[0] = bne(2'd0);
        alu_taken_b = 1'b1;
        applyStimulus(1, "wdog", 0);
        checkOutput("wdog_timeout", 32'(timeout_b),   32'd1);
        checkOutput("wdog_cnt",     32'(cycle_cnt_b), 32'd6);
        checkOutput("wdog_commits", cmask_b,          32'h14);
        checkOutput("wdog_pc",      32'(imem_addr_b), 32'd0);
        checkOutput("wdog_overrun", 32'(overrun_b),   32'd0);
        endRun(1, "wdog");
        checkOutput("wdog_flag_hold", 32'(timeout_b), 32'd1);

        rom_c[7] = ADD;
        applyStimulus(2, "ovr", 0);
        checkOutput("ovr_flag",    32'(overrun_c),   32'd1);
        checkOutput("ovr_commits", cmask_c,          32'h4);
        checkOutput("ovr_cnt",     32'(cycle_cnt_c), 32'd2);
        checkOutput("ovr_pc",      32'(imem_addr_c), 32'd7);
        checkOutput("ovr_memreq",  mmask_c,          32'h0);
        endRun(2, "ovr");

        rom_a[0] = LOAD; rom_a[1] = HALT;
        @(negedge clk);
        req_a = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("mid_pre_commit", 32'(commit_a),    32'd1);
        checkOutput("mid_pre_cnt",    32'(cycle_cnt_a), 32'd2);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("mid_commit", 32'(commit_a),    32'd0);
        checkOutput("mid_busy",   32'(busy_a),      32'd0);
        checkOutput("mid_memreq", 32'(mem_req_a),   32'd0);
        checkOutput("mid_cnt",    32'(cycle_cnt_a), 32'd0);
        checkOutput("mid_ir",     32'(ir_a),        32'd0);
        checkOutput("mid_pc",     32'(imem_addr_a), 32'd0);
        checkOutput("mid_timeout_b", 32'(timeout_b), 32'd0);
        req_a = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        cmask_a = '0;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_commits", cmask_a,        32'h0);
        checkOutput("post_rst_busy",    32'(busy_a),    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
